// File: rtl/tp_ram_rd_streamer.sv
// tp_ram_rd_streamer: read-side sequencer for the two-port RAM.
// Walks a contiguous address range and tags each issued read. It absorbs the
// RAM's fixed read latency and replays the returning words as a
// valid/ready stream with a last marker, through a small skid FIFO.
// Optional build macro RD_STREAM_LOOP_EN adds the 'loop' input. With loop set,
// the command replays its range endlessly until reset.
module tp_ram_rd_streamer #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
`ifdef RD_STREAM_LOOP_EN
    input  logic          loop,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_radr,
    input  logic [DW-1:0] ram_rdat,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW:0]       rem_q, rem_d;
    logic [AW-1:0]     radr_q, radr_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [RD_LAT-1:0] tlast_q, tlast_d;
    logic [DW-1:0]     fdata_q [FIFO_DEPTH];
    logic              flast_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     cur_addr;
    logic [AW:0]       cur_rem;
    logic              issue, issue_last, credit_ok, push, pop;

    function automatic int tag_count(input logic [RD_LAT-1:0] t);
        int n;
        n = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (t[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef RD_STREAM_LOOP_EN
    logic          loop_q, loop_cur;
    logic [AW-1:0] base_q, base_cur;
    logic [AW:0]   len_q, len_cur;

    assign loop_cur = (state_q == IDLE) ? loop : loop_q;
    assign base_cur = (state_q == IDLE) ? base : base_q;
    assign len_cur  = (state_q == IDLE) ? len  : len_q;

    // Loop flag is control state; base/len are only replay operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_q <= 1'b0;
        end else if (state_q == IDLE && start && len != '0) begin
            loop_q <= loop;
        end
        if (state_q == IDLE && start && len != '0) begin
            base_q <= base;
            len_q  <= len;
        end
    end
`endif

    // Credit excludes a same-cycle pop, so a returning word always finds room.
    assign credit_ok = (tag_count(tag_q) + int'(cnt_q)) < FIFO_DEPTH;
    assign push      = tag_q[RD_LAT-1];
    assign pop       = m_valid && m_ready;

    // FSM next state plus read issue; the first read goes out on the accept edge.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        radr_d     = radr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        cur_addr   = (state_q == IDLE) ? base : addr_q;
        cur_rem    = (state_q == IDLE) ? len  : rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) state_d = DONE;
                    else           issue   = 1'b1;
                end
            end
            RUN:     issue = credit_ok;
            DRAIN:   if (pop && m_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (issue) begin
            radr_d     = cur_addr;
            addr_d     = cur_addr + AW'(1);
            issue_last = (cur_rem == LEN_ONE);
            if (issue_last) begin
                rem_d   = '0;
                state_d = DRAIN;
            end else begin
                rem_d   = cur_rem - LEN_ONE;
                state_d = RUN;
            end
`ifdef RD_STREAM_LOOP_EN
            if (issue_last && loop_cur) begin
                addr_d  = base_cur;
                rem_d   = len_cur;
                state_d = RUN;
            end
`endif
        end
    end

    // Tag pipeline mirrors the RAM latency; only tagged return slots are kept.
    always_comb begin
        tag_d      = '0;
        tlast_d    = '0;
        tag_d[0]   = issue;
        tlast_d[0] = issue && issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i]   = tag_q[i-1];
            tlast_d[i] = tlast_q[i-1];
        end
    end

    // FIFO occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    // Control registers, all cleared by reset (aborts any command in flight).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            radr_q  <= '0;
            tag_q   <= '0;
            tlast_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            radr_q  <= radr_d;
            tag_q   <= tag_d;
            tlast_q <= tlast_d;
            cnt_q   <= cnt_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
        end
    end

    // FIFO storage; contents are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fdata_q[wptr_q] <= ram_rdat;
            flast_q[wptr_q] <= tlast_q[RD_LAT-1];
        end
    end

    // A push into a full FIFO would mean the credit rule is broken.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
    end

    assign m_valid  = (cnt_q != '0);
    assign m_data   = m_valid ? fdata_q[rptr_q] : '0;
    assign m_last   = m_valid && flast_q[rptr_q];
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign ram_radr = radr_q;

endmodule
